gemm_cmd_regs: RTL and testbench

- System-bus responder for the GEMM accelerator's memory-mapped configuration window.
- Captures tile addresses, strides, control and dimension writes from the host into staging registers.
- A write to GEMM_DIM commits the staged set as one command into a CMD_DEPTH-entry FIFO; the GEMM engine pops commands over a valid/ready handshake.
- Returns FIFO-full status and completion status to host polls.

---
 rtl/gemm_cmd_regs.sv | 247 ++++++++++++++++++++++++
 tb/tb_gemm_cmd_regs.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_cmd_regs.sv
// Memory-mapped command staging registers and command FIFO for the GEMM engine.
// Optional feature: define GEMM_CMD_OVF_EN for the dropped-commit counter at offset 28.
module gemm_cmd_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          CMD_DEPTH = 4,
    parameter int          DIM_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             system_bus_en,
    input  logic             system_bus_rdwr,
    input  logic [31:0]      system_bus_addr,
    input  logic [31:0]      system_bus_wr_data,
    output logic [31:0]      system_bus_rd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [31:0]      cmd_a_addr,
    output logic [31:0]      cmd_b_addr,
    output logic [31:0]      cmd_c_addr,
    output logic [31:0]      cmd_a_stride,
    output logic [31:0]      cmd_b_stride,
    output logic             cmd_first,
    output logic             cmd_last,
    output logic [DIM_W-1:0] cmd_msize,
    output logic [DIM_W-1:0] cmd_ksize,
    output logic [DIM_W-1:0] cmd_nsize,
    input  logic             cmd_done
);

    localparam int IDX_W = $clog2(CMD_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OFF_A_ADDR   = 3'd0,
        OFF_B_ADDR   = 3'd1,
        OFF_C_ADDR   = 3'd2,
        OFF_A_STRIDE = 3'd3,
        OFF_B_STRIDE = 3'd4,
        OFF_CTRL     = 3'd5,
        OFF_DIM      = 3'd6,
        OFF_RSVD     = 3'd7
    } reg_off_e;

    typedef struct packed {
        logic [31:0]      a_addr;
        logic [31:0]      b_addr;
        logic [31:0]      c_addr;
        logic [31:0]      a_stride;
        logic [31:0]      b_stride;
        logic             first;
        logic             last;
        logic [DIM_W-1:0] msize;
        logic [DIM_W-1:0] ksize;
        logic [DIM_W-1:0] nsize;
    } cmd_t;

    logic [31:0] stg_a_addr;
    logic [31:0] stg_b_addr;
    logic [31:0] stg_c_addr;
    logic [31:0] stg_a_stride;
    logic [31:0] stg_b_stride;
    logic [1:0]  stg_ctrl;

    cmd_t             fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    cmd_t             head;
    cmd_t             push_cmd;

    logic     base_hit;
    logic     wr_hit;
    logic     rd_hit;
    reg_off_e offset;
    logic     commit_req;
    logic     push;
    logic     drop;
    logic     pop;
    logic     dispatch_ok;

    logic busy;
    logic done_seen;
    logic done_evt;
    logic done;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^system_bus_addr[1:0];

    assign base_hit   = system_bus_en && (system_bus_addr[31:5] == BASE_ADDR[31:5]);
    assign wr_hit     = base_hit && system_bus_rdwr;
    assign rd_hit     = base_hit && !system_bus_rdwr;
    assign offset     = reg_off_e'(system_bus_addr[4:2]);

    // A drop is judged on the occupancy before the edge, so a same-edge pop never rescues it.
    assign commit_req = wr_hit && (offset == OFF_DIM);
    assign push       = commit_req && !fifo_full;
    assign drop       = commit_req && fifo_full;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    assign cmd_valid  = !fifo_empty && dispatch_ok;
    assign pop        = cmd_valid && cmd_ready;

    // Completion only counts for a command the engine actually owns.
    assign done_evt   = cmd_done && busy;
    assign done       = done_seen && !busy && fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_a_addr   <= '0;
            stg_b_addr   <= '0;
            stg_c_addr   <= '0;
            stg_a_stride <= '0;
            stg_b_stride <= '0;
            stg_ctrl     <= '0;
        end else if (wr_hit) begin
            case (offset)
                OFF_A_ADDR:   stg_a_addr   <= system_bus_wr_data;
                OFF_B_ADDR:   stg_b_addr   <= system_bus_wr_data;
                OFF_C_ADDR:   stg_c_addr   <= system_bus_wr_data;
                OFF_A_STRIDE: stg_a_stride <= system_bus_wr_data;
                OFF_B_STRIDE: stg_b_stride <= system_bus_wr_data;
                OFF_CTRL:     stg_ctrl     <= system_bus_wr_data[1:0];
                default:      ;
            endcase
        end
    end

    // Dimensions come straight off the bus so the DIM write and the push share one edge.
    always_comb begin
        push_cmd          = '0;
        push_cmd.a_addr   = stg_a_addr;
        push_cmd.b_addr   = stg_b_addr;
        push_cmd.c_addr   = stg_c_addr;
        push_cmd.a_stride = stg_a_stride;
        push_cmd.b_stride = stg_b_stride;
        push_cmd.first    = stg_ctrl[1];
        push_cmd.last     = stg_ctrl[0];
        push_cmd.msize    = system_bus_wr_data[DIM_W-1:0];
        push_cmd.ksize    = system_bus_wr_data[2*DIM_W-1:DIM_W];
        push_cmd.nsize    = system_bus_wr_data[3*DIM_W-1:2*DIM_W];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = fifo_mem[rd_ptr[IDX_W-1:0]];
        end
    end

    assign cmd_a_addr   = head.a_addr;
    assign cmd_b_addr   = head.b_addr;
    assign cmd_c_addr   = head.c_addr;
    assign cmd_a_stride = head.a_stride;
    assign cmd_b_stride = head.b_stride;
    assign cmd_first    = head.first;
    assign cmd_last     = head.last;
    assign cmd_msize    = head.msize;
    assign cmd_ksize    = head.ksize;
    assign cmd_nsize    = head.nsize;

    // A new pop wins over a same-edge completion; a new commit wins over a same-edge completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (pop) begin
                busy <= 1'b1;
            end else if (done_evt) begin
                busy <= 1'b0;
            end
            if (push) begin
                done_seen <= 1'b0;
            end else if (done_evt) begin
                done_seen <= 1'b1;
            end
        end
    end

`ifdef GEMM_CMD_OVF_EN
    logic [15:0] drop_cnt;

    // Any nonzero count blocks dispatch until the host acknowledges the lost tile.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (wr_hit && (offset == OFF_RSVD)) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign dispatch_ok = (drop_cnt == 16'd0);
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign dispatch_ok = 1'b1;
`endif

    always_comb begin
        system_bus_rd_data = '0;
        if (rd_hit) begin
            case (offset)
                OFF_A_ADDR:   system_bus_rd_data = {31'b0, fifo_full};
                OFF_B_ADDR:   system_bus_rd_data = stg_b_addr;
                OFF_C_ADDR:   system_bus_rd_data = stg_c_addr;
                OFF_A_STRIDE: system_bus_rd_data = stg_a_stride;
                OFF_B_STRIDE: system_bus_rd_data = stg_b_stride;
                OFF_CTRL:     system_bus_rd_data = {30'b0, stg_ctrl};
                OFF_DIM:      system_bus_rd_data = {31'b0, done};
`ifdef GEMM_CMD_OVF_EN
                OFF_RSVD:     system_bus_rd_data = {16'b0, drop_cnt};
`else
                OFF_RSVD:     system_bus_rd_data = '0;
`endif
                default:      system_bus_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_cmd_regs.sv
// Self-checking bench for gemm_cmd_regs: read-decode/commit tables, scoreboard of queued commands.
// Covers the GEMM_CMD_OVF_EN build as well when that macro is defined.
module tb_gemm_cmd_regs;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam logic [31:0] DIM16 = 32'd16912;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [31:0] system_bus_rd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a_addr;
    logic [31:0] cmd_b_addr;
    logic [31:0] cmd_c_addr;
    logic [31:0] cmd_a_stride;
    logic [31:0] cmd_b_stride;
    logic        cmd_first;
    logic        cmd_last;
    logic [4:0]  cmd_msize;
    logic [4:0]  cmd_ksize;
    logic [4:0]  cmd_nsize;
    logic        cmd_done;

    typedef struct packed {
        logic [31:0] a_addr;
        logic [31:0] b_addr;
        logic [31:0] c_addr;
        logic [31:0] a_stride;
        logic [31:0] b_stride;
        logic        first;
        logic        last;
        logic [4:0]  msize;
        logic [4:0]  ksize;
        logic [4:0]  nsize;
    } exp_cmd_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        en;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [31:0] c_addr;
        logic        exp_full;
    } commit_vec_t;

    exp_cmd_t    sb_q[$];
    exp_cmd_t    stage;
    exp_cmd_t    head_act;
    int          ovf_model;
    int          total;
    int          bad;
    rd_vec_t     rtab[11];
    commit_vec_t ctab[5];

    gemm_cmd_regs dut (
        .clk(clk),
        .rst(rst),
        .system_bus_en(system_bus_en),
        .system_bus_rdwr(system_bus_rdwr),
        .system_bus_addr(system_bus_addr),
        .system_bus_wr_data(system_bus_wr_data),
        .system_bus_rd_data(system_bus_rd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a_addr(cmd_a_addr),
        .cmd_b_addr(cmd_b_addr),
        .cmd_c_addr(cmd_c_addr),
        .cmd_a_stride(cmd_a_stride),
        .cmd_b_stride(cmd_b_stride),
        .cmd_first(cmd_first),
        .cmd_last(cmd_last),
        .cmd_msize(cmd_msize),
        .cmd_ksize(cmd_ksize),
        .cmd_nsize(cmd_nsize),
        .cmd_done(cmd_done)
    );

    assign head_act = {cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_a_stride, cmd_b_stride,
                       cmd_first, cmd_last, cmd_msize, cmd_ksize, cmd_nsize};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus write with a reference model of staging, FIFO occupancy and drop count.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        exp_cmd_t c;
        system_bus_en      = 1'b1;
        system_bus_rdwr    = 1'b1;
        system_bus_addr    = addr;
        system_bus_wr_data = data;
        if (addr[31:5] == BASE[31:5]) begin
            case (addr[4:2])
                3'd0: stage.a_addr   = data;
                3'd1: stage.b_addr   = data;
                3'd2: stage.c_addr   = data;
                3'd3: stage.a_stride = data;
                3'd4: stage.b_stride = data;
                3'd5: begin
                    stage.first = data[1];
                    stage.last  = data[0];
                end
                3'd6: begin
                    c       = stage;
                    c.msize = data[4:0];
                    c.ksize = data[9:5];
                    c.nsize = data[14:10];
                    if (sb_q.size() < DEPTH) sb_q.push_back(c);
                    else if (ovf_model < 65535) ovf_model++;
                end
                default: ovf_model = 0;
            endcase
        end
        @(posedge clk);
        #1;
        system_bus_en = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, input logic en, output logic [31:0] data);
        system_bus_en   = en;
        system_bus_rdwr = 1'b0;
        system_bus_addr = addr;
        #2;
        data = system_bus_rd_data;
        system_bus_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRead(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        readReg(addr, 1'b1, d);
        checkOutput(name, d, exp);
    endtask

    task automatic popOne(input string name);
        checkOutput({name, "_valid"}, cmd_valid, 1'b1);
        if (sb_q.size() > 0) checkOutput({name, "_head"}, head_act, sb_q[0]);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic pulseDone();
        cmd_done = 1'b1;
        @(posedge clk);
        #1;
        cmd_done = 1'b0;
    endtask

    task automatic commitC(input logic [31:0] c);
        applyStimulus(BASE + 8, c);
        applyStimulus(BASE + 24, DIM16);
    endtask

    initial begin
        logic [31:0] d;
        total = 0;
        bad = 0;
        ovf_model = 0;
        stage = '0;
        rst = 1'b0;
        system_bus_en = 1'b0;
        system_bus_rdwr = 1'b0;
        system_bus_addr = '0;
        system_bus_wr_data = '0;
        cmd_ready = 1'b0;
        cmd_done = 1'b0;

        rtab[0]  = '{"rd_full0",   BASE + 0,      1'b1, 32'd0};
        rtab[1]  = '{"rd_b",       BASE + 4,      1'b1, 32'd780};
        rtab[2]  = '{"rd_c",       BASE + 8,      1'b1, 32'd800};
        rtab[3]  = '{"rd_sa",      BASE + 12,     1'b1, 32'd20};
        rtab[4]  = '{"rd_sb",      BASE + 16,     1'b1, 32'd20};
        rtab[5]  = '{"rd_ctrl",    BASE + 20,     1'b1, 32'd3};
        rtab[6]  = '{"rd_done0",   BASE + 24,     1'b1, 32'd0};
        rtab[7]  = '{"rd_rsvd",    BASE + 28,     1'b1, 32'd0};
        rtab[8]  = '{"rd_b_lsb",   BASE + 7,      1'b1, 32'd780};
        rtab[9]  = '{"rd_badbase", 32'h8000_0004, 1'b1, 32'd0};
        rtab[10] = '{"rd_en0",     BASE + 4,      1'b0, 32'd0};

        ctab[0] = '{32'd1, 1'b0};
        ctab[1] = '{32'd2, 1'b0};
        ctab[2] = '{32'd3, 1'b0};
        ctab[3] = '{32'd4, 1'b1};
        ctab[4] = '{32'd5, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        checkOutput("rst_valid", cmd_valid, 1'b0);
        checkOutput("rst_head", head_act, '0);
        checkRead("rst_full", BASE + 0, 32'd0);
        checkRead("rst_done", BASE + 24, 32'd0);

        applyStimulus(BASE + 0, 32'd0);
        applyStimulus(BASE + 4, 32'd780);
        applyStimulus(BASE + 8, 32'd800);
        applyStimulus(BASE + 12, 32'd20);
        applyStimulus(BASE + 16, 32'd20);
        applyStimulus(BASE + 20, 32'd3);
        applyStimulus(BASE + 24, DIM16);
        checkOutput("cfg_valid", cmd_valid, 1'b1);
        checkOutput("cfg_head", head_act, sb_q[0]);
        checkOutput("cfg_msize", cmd_msize, 5'd16);
        checkOutput("cfg_b", cmd_b_addr, 32'd780);
        for (int i = 0; i < 11; i++) begin
            readReg(rtab[i].addr, rtab[i].en, d);
            checkOutput(rtab[i].name, d, rtab[i].exp);
        end

        popOne("pop_cfg");
        checkRead("busy_done0", BASE + 24, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        checkRead("busy_done0_late", BASE + 24, 32'd0);
        pulseDone();
        checkRead("done1", BASE + 24, 32'd1);
        applyStimulus(BASE + 24, DIM16);
        checkRead("done_cleared", BASE + 24, 32'd0);
        popOne("pop_recommit");
        pulseDone();

        for (int i = 0; i < 5; i++) begin
            commitC(ctab[i].c_addr);
            checkRead($sformatf("full_after_%0d", i + 1), BASE + 0, {31'b0, ctab[i].exp_full});
        end
`ifdef GEMM_CMD_OVF_EN
        checkOutput("ovf_blocks_valid", cmd_valid, 1'b0);
        checkRead("ovf_cnt1", BASE + 28, ovf_model);
        applyStimulus(BASE + 28, 32'd0);
`endif
        for (int i = 0; i < 4; i++) popOne($sformatf("drain_%0d", i + 1));
        checkOutput("drain_empty", cmd_valid, 1'b0);
        pulseDone();

        for (int i = 11; i <= 14; i++) commitC(i);
        checkRead("sim_full", BASE + 0, 32'd1);
        applyStimulus(BASE + 8, 32'd15);
        checkOutput("sim_head", head_act, sb_q[0]);
        cmd_ready = 1'b1;
        applyStimulus(BASE + 24, DIM16);
        cmd_ready = 1'b0;
        void'(sb_q.pop_front());
`ifdef GEMM_CMD_OVF_EN
        applyStimulus(BASE + 28, 32'd0);
`endif
        checkRead("sim_not_full", BASE + 0, 32'd0);
        for (int i = 0; i < 3; i++) popOne($sformatf("sim_pop_%0d", i + 1));
        checkOutput("sim_occ3", cmd_valid, 1'b0);

        commitC(32'd20);
        cmd_done = 1'b1;
        popOne("pop_with_done");
        cmd_done = 1'b0;
        checkRead("busy_kept", BASE + 24, 32'd0);
        pulseDone();
        checkRead("done_after_busy", BASE + 24, 32'd1);

        applyStimulus(32'h8000_0018, DIM16);
        checkOutput("badbase_nocommit", cmd_valid, 1'b0);
        checkRead("badbase_done_kept", BASE + 24, 32'd1);
        applyStimulus(BASE + 28, 32'hDEAD_BEEF);
        checkRead("rsvd_zero", BASE + 28, 32'd0);

        commitC(32'd31);
        commitC(32'd32);
        checkOutput("pre_rst_valid", cmd_valid, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        stage = '0;
        ovf_model = 0;
        checkOutput("mid_rst_valid", cmd_valid, 1'b0);
        checkOutput("mid_rst_head", head_act, '0);
        for (int i = 0; i < 8; i++) checkRead($sformatf("mid_rst_rd_%0d", i * 4), BASE + 32'(i * 4), 32'd0);
        pulseDone();
        checkRead("rst_done_ignored", BASE + 24, 32'd0);

`ifdef GEMM_CMD_OVF_EN
        for (int i = 0; i < 6; i++) commitC(32'(40 + i));
        checkRead("ovf_cnt2", BASE + 28, 32'd2);
        checkOutput("ovf_valid0", cmd_valid, 1'b0);
        applyStimulus(BASE + 28, 32'd0);
        checkRead("ovf_cleared", BASE + 28, 32'd0);
        checkOutput("ovf_valid1", cmd_valid, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
